// File: rtl/mem_1r1w_fifo.sv
// mem_1r1w_fifo: ready/valid FIFO controller wrapped around the mem_1r1w
// dual-port SRAM macro (registered read, one-cycle read latency).
// Words are written through the macro write port. They are read back
// ahead of demand into a 2-entry output queue, so the head stays
// show-ahead and registered.
// Optional feature: define MEM_FIFO_BYPASS_EN to let an enqueue into an
// idle FIFO skip the macro and land directly in the output queue.
// Without it, every word takes the macro path (3-cycle empty latency).
module mem_1r1w_fifo #(
    parameter int DEPTH   = 48,
    parameter int WIDTH   = 64,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int COUNT_W = $clog2(DEPTH + 3)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enq_valid,
    output logic               enq_ready,
    input  logic [WIDTH-1:0]   enq_data,
    output logic               deq_valid,
    input  logic               deq_ready,
    output logic [WIDTH-1:0]   deq_data,
    output logic [COUNT_W-1:0] count,
    output logic [ADDR_W-1:0]  R0_addr,
    output logic               R0_en,
    output logic               R0_clk,
    input  logic [WIDTH-1:0]   R0_data,
    output logic [ADDR_W-1:0]  W0_addr,
    output logic               W0_en,
    output logic               W0_clk,
    output logic [WIDTH-1:0]   W0_data
);

    // Pointer increment that wraps at DEPTH-1 (DEPTH need not be 2^n).
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [ADDR_W-1:0]       wptr, rptr;
    logic [COUNT_W-1:0]      mem_cnt;   // words in the macro, not yet read
    logic                    inflight;  // read issued last cycle, data on R0_data now
    logic [1:0][WIDTH-1:0]   oq;        // oq[0] is always the head
    logic [1:0]              oq_cnt;
    logic                    deq_vld_q;

    logic                    enq_fire, deq_fire, bypass, mem_wr, rd_issue;
    logic [2:0]              oq_occ_next;
    logic                    push_vld;
    logic [WIDTH-1:0]        push_data;
    logic [1:0][WIDTH-1:0]   oq_n;
    logic [1:0]              oq_cnt_n, oq_cnt_p;

    // Flow control depends only on registered macro occupancy. Writes are
    // gated by reset_n so nothing reaches the macro while reset is held.
    assign enq_ready = (mem_cnt < COUNT_W'(DEPTH));
    assign enq_fire  = enq_valid & enq_ready & reset_n;
    assign deq_valid = deq_vld_q;
    assign deq_data  = oq[0];
    assign deq_fire  = deq_vld_q & deq_ready;

`ifdef MEM_FIFO_BYPASS_EN
    // Idle pipeline: the word goes straight to the output queue, ahead of
    // nothing, so ordering holds.
    assign bypass = enq_fire & (mem_cnt == '0) & ~inflight & (oq_cnt != 2'd2);
`else
    assign bypass = 1'b0;
`endif

    assign mem_wr = enq_fire & ~bypass;

    // Occupancy the output queue will have once this cycle's in-flight word
    // lands and any pop retires. A new read may only be issued if its data
    // is guaranteed a free slot next cycle.
    assign oq_occ_next = 3'(oq_cnt) + 3'(inflight) - 3'(deq_fire);
    assign rd_issue    = (mem_cnt != '0) & (oq_occ_next < 3'd2);

    // Macro port drive.
    assign W0_clk  = clock;
    assign W0_en   = mem_wr;
    assign W0_addr = wptr;
    assign W0_data = enq_data;
    assign R0_clk  = clock;
    assign R0_en   = rd_issue;
    assign R0_addr = rptr;

    assign count = mem_cnt + COUNT_W'(inflight) + COUNT_W'(oq_cnt);

    // Inflight and bypass pushes are mutually exclusive (bypass needs
    // inflight==0), so one push source suffices.
    assign push_vld  = inflight | bypass;
    assign push_data = inflight ? R0_data : enq_data;

    // Output queue next state: pop shifts the tail to the head, then a push
    // fills the first free slot.
    always_comb begin
        oq_n     = oq;
        oq_cnt_p = oq_cnt - {1'b0, deq_fire};
        if (deq_fire)
            oq_n[0] = oq[1];
        if (push_vld) begin
            if (oq_cnt_p == 2'd0)
                oq_n[0] = push_data;
            else
                oq_n[1] = push_data;
        end
        oq_cnt_n = oq_cnt_p + {1'b0, push_vld};
    end

    // Control state: pointers, occupancy, in-flight flag, registered deq_valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr      <= '0;
            rptr      <= '0;
            mem_cnt   <= '0;
            inflight  <= 1'b0;
            oq_cnt    <= '0;
            deq_vld_q <= 1'b0;
        end else begin
            if (mem_wr)
                wptr <= ptr_inc(wptr);
            if (rd_issue)
                rptr <= ptr_inc(rptr);
            case ({mem_wr, rd_issue})
                2'b10:   mem_cnt <= mem_cnt + 1'b1;
                2'b01:   mem_cnt <= mem_cnt - 1'b1;
                default: mem_cnt <= mem_cnt;
            endcase
            inflight  <= rd_issue;
            oq_cnt    <= oq_cnt_n;
            deq_vld_q <= (oq_cnt_n != 2'd0);
        end
    end

    // Output queue data; contents are qualified by oq_cnt, so no reset.
    always_ff @(posedge clock) begin
        oq <= oq_n;
    end

endmodule

// File: tb/tb_mem_1r1w_fifo.sv
// Bench for mem_1r1w_fifo: behavioural mem_1r1w macro, directed stimulus,
// scoreboard queue of accepted words, negedge monitor for deq/count/reset.
module tb_mem_1r1w_fifo;

    localparam int DEPTH = 48;
    localparam int WIDTH = 64;
`ifdef MEM_FIFO_BYPASS_EN
    localparam int EXP_LAT = 1;
    localparam int EXP_RD  = 0;
`else
    localparam int EXP_LAT = 3;
    localparam int EXP_RD  = 2;
`endif

    logic             clock = 1'b0;
    logic             reset_n;
    logic             enq_valid, enq_ready, deq_valid, deq_ready;
    logic [WIDTH-1:0] enq_data, deq_data;
    logic [5:0]       count;
    logic [5:0]       R0_addr, W0_addr;
    logic             R0_en, R0_clk, W0_en, W0_clk;
    logic [WIDTH-1:0] R0_data, W0_data;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int mcnt = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] macro_mem [DEPTH];

    mem_1r1w_fifo dut (
        .clock(clock), .reset_n(reset_n),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data),
        .count(count),
        .R0_addr(R0_addr), .R0_en(R0_en), .R0_clk(R0_clk), .R0_data(R0_data),
        .W0_addr(W0_addr), .W0_en(W0_en), .W0_clk(W0_clk), .W0_data(W0_data)
    );

    always #5 clock = ~clock;

    // Behavioural macro: registered read, one-cycle latency.
    always @(posedge clock) begin
        if (W0_en) begin
            macro_mem[W0_addr] <= W0_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (R0_en)
            R0_data <= macro_mem[R0_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Monitor: mid-cycle, inputs and outputs are stable.
    always @(negedge clock) begin
        if (!reset_n) begin
            exp_q.delete();
            mcnt = 0;
            chk("rst_enq_ready", 64'(enq_ready), 64'd1);
            chk("rst_deq_valid", 64'(deq_valid), 64'd0);
            chk("rst_count", 64'(count), 64'd0);
            chk("rst_r0_en", 64'(R0_en), 64'd0);
            chk("rst_w0_en", 64'(W0_en), 64'd0);
        end else begin
            chk("count", 64'(count), 64'(mcnt));
            if (deq_valid && deq_ready) begin
                if (exp_q.size() == 0) begin
                    chk("deq_unexpected", 64'(deq_valid), 64'd0);
                end else begin
                    chk("deq_data", deq_data, exp_q.pop_front());
                end
                mcnt--;
            end
            if (enq_valid && enq_ready) begin
                exp_q.push_back(enq_data);
                mcnt++;
            end
            if (R0_en)
                rd_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, rd0, n;
        bit found;

        // Reset with enq_valid held high.
        reset_n   = 1'b0;
        enq_valid = 1'b1;
        enq_data  = 64'hFFFF_0000_FFFF_0000;
        deq_ready = 1'b0;
        repeat (4) step();
        chk("rst_no_write", 64'(wr_cnt), 64'd0);
        reset_n   = 1'b1;
        enq_valid = 1'b0;
        step();

        // Single enqueue into empty FIFO: empty-to-valid latency.
        enq_valid = 1'b1;
        enq_data  = 64'hDEADBEEF_00000001;
        step();
        enq_valid = 1'b0;
        lat = 1;
        while (!deq_valid && lat < 10) begin
            step();
            lat++;
        end
        chk("empty_latency", 64'(lat), 64'(EXP_LAT));
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
`ifdef MEM_FIFO_BYPASS_EN
        chk("bypass_no_write", 64'(wr_cnt), 64'd0);
`endif

        // Fill with values 0..49, consumer stalled.
        rd0 = rd_cnt;
        for (int i = 0; i < DEPTH + 2; i++) begin
            chk("fill_enq_ready", 64'(enq_ready), 64'd1);
            enq_valid = 1'b1;
            enq_data  = 64'(i);
            step();
        end
        enq_valid = 1'b0;
        chk("full_enq_ready", 64'(enq_ready), 64'd0);
        chk("full_count", 64'(count), 64'd50);
        chk("fill_reads", 64'(rd_cnt - rd0), 64'(EXP_RD));

        // Drain: one word per cycle without a gap (scoreboard checks order).
        deq_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            chk("drain_valid", 64'(deq_valid), 64'd1);
            step();
        end
        deq_ready = 1'b0;
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_deq_valid", 64'(deq_valid), 64'd0);

        // Random streaming against the scoreboard.
        for (int i = 0; i < 10000; i++) begin
            enq_valid = 1'($urandom_range(0, 1));
            enq_data  = {32'hC0DE_0000, 32'(i)};
            deq_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        n = 0;
        while (count != 0 && n < 200) begin
            step();
            n++;
        end
        chk("stream_final_count", 64'(count), 64'd0);
        chk("stream_q_empty", 64'(exp_q.size()), 64'd0);

        // Reset while a read is in flight.
        deq_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            enq_valid = 1'b1;
            enq_data  = 64'h1000 + 64'(i);
            step();
        end
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (R0_en) found = 1'b1;
        end
        chk("midrst_read_seen", 64'(found), 64'd1);
        @(posedge clock);
        #1;
        reset_n   = 1'b0;
        deq_ready = 1'b0;
        #1;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_deq_valid", 64'(deq_valid), 64'd0);
        chk("midrst_enq_ready", 64'(enq_ready), 64'd1);
        step();
        step();
        reset_n   = 1'b1;
        enq_valid = 1'b1;
        enq_data  = 64'h5;
        step();
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        n = 0;
        while (!deq_valid && n < 10) begin
            step();
            n++;
        end
        chk("postrst_valid", 64'(deq_valid), 64'd1);
        chk("postrst_data", deq_data, 64'h5);
        step();
        step();
        chk("postrst_empty", 64'(count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
